// File: rtl/pkt_arb_mux.sv
// N-channel packet-level stream multiplexer: one channel is granted for a whole
// packet (through its last beat), feeding a single registered output stage.
module pkt_arb_mux #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = 0,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          s_valid,
    input  logic [N_CH-1:0]          s_last,
    input  logic [N_CH*DATA_W-1:0]   s_data,
    output logic [N_CH-1:0]          s_ready,
    output logic                     m_valid,
    output logic                     m_last,
    output logic [DATA_W-1:0]        m_data,
    output logic [SEL_W-1:0]         m_sel,
    input  logic                     m_ready
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  grant_next;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_ptr_next;
    logic [SEL_W-1:0]  winner;

    logic [N_CH-1:0]   hi_mask;
    logic [N_CH-1:0]   masked_valid;
    logic [N_CH-1:0]   search_vec;
    logic              found;

    logic              ld;
    logic              in_xfer;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;

    // Round-robin search: requests at or above rr_ptr take precedence; if none,
    // fall back to the lowest request overall, which gives the wrap-around.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            hi_mask[i] = (i >= 32'(rr_ptr));
        end
        masked_valid = s_valid & hi_mask;
        if (ARB_MODE == 0 && masked_valid != '0) begin
            search_vec = masked_valid;
        end else begin
            search_vec = s_valid;
        end
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && search_vec[i]) begin
                winner = SEL_W'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                g_valid = s_valid[i];
                g_last  = s_last[i];
                g_data  = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ld      = !m_valid || m_ready;
    assign in_xfer = (state == BUSY) && ld && g_valid;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            s_ready[i] = (state == BUSY) && ld && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        rr_ptr_next = rr_ptr;
        case (state)
            IDLE: begin
                if (s_valid != '0) begin
                    grant_next = winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && g_last) begin
                    state_next  = IDLE;
                    rr_ptr_next = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // Output register: a drained beat clears valid only; data/last/sel hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_last  <= g_last;
            m_data  <= g_data;
            m_sel   <= grant;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_arb_mux.sv
// Bench for pkt_arb_mux: round-robin and fixed-priority instances share stimulus;
// a cycle-level model is compared every cycle and output logs pin directed cases.
module tb_pkt_arb_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_last;
    logic [N*W-1:0] s_data;
    logic           m_ready;

    logic [N-1:0]   s_ready_w [2];
    logic           m_valid_w [2];
    logic           m_last_w  [2];
    logic [W-1:0]   m_data_w  [2];
    logic [1:0]     m_sel_w   [2];

    always #5 clk = ~clk;

    pkt_arb_mux #(.N_CH(N), .DATA_W(W), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready_w[0]), .m_valid(m_valid_w[0]), .m_last(m_last_w[0]),
        .m_data(m_data_w[0]), .m_sel(m_sel_w[0]), .m_ready(m_ready)
    );

    pkt_arb_mux #(.N_CH(N), .DATA_W(W), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready_w[1]), .m_valid(m_valid_w[1]), .m_last(m_last_w[1]),
        .m_data(m_data_w[1]), .m_sel(m_sel_w[1]), .m_ready(m_ready)
    );

    int checks = 0;
    int errors = 0;
    int act    = 0;
    int cyc    = 0;
    bit started = 1'b0;

    logic [8:0] srcq [N][$];
    bit         mr_q [$];
    logic [N-1:0] last_acc;

    typedef struct {
        int sel;
        int data;
        int last;
        int cyc;
    } beat_t;
    beat_t olog [$];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model state per instance: busy flag, granted channel, next-start pointer, output register.
    int mb [2];
    int mg [2];
    int mp [2];
    int md [2];
    int ms [2];
    bit mv [2];
    bit ml [2];
    bit wb;
    bit room;

    function automatic int pick(input int u);
        int base;
        base = (u == 1) ? 0 : mp[u];
        for (int k = 0; k < N; k++) begin
            if (s_valid[(base + k) % N]) return (base + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) started = 1'b1;
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                mb[u] = 0; mg[u] = 0; mp[u] = 0; md[u] = 0; ms[u] = 0;
                mv[u] = 1'b0; ml[u] = 1'b0;
            end else begin
                wb   = (mb[u] != 0);
                room = !mv[u] || m_ready;
                if (wb && room && s_valid[mg[u]]) begin
                    mv[u] = 1'b1;
                    md[u] = int'(s_data[mg[u]*W +: W]);
                    ml[u] = s_last[mg[u]];
                    ms[u] = mg[u];
                    if (s_last[mg[u]]) begin
                        mb[u] = 0;
                        mp[u] = (mg[u] + 1) % N;
                    end
                end else if (m_ready) begin
                    mv[u] = 1'b0;
                end
                if (!wb && s_valid != '0) begin
                    mb[u] = 1;
                    mg[u] = pick(u);
                end
            end
        end
    end

    bit         ph [2] = '{1'b0, 1'b0};
    logic [W-1:0] pd [2];

    always @(negedge clk) begin
        if (started) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("dut%0d m_valid", u), int'(m_valid_w[u]), int'(mv[u]));
                chk($sformatf("dut%0d m_data", u), int'(m_data_w[u]), md[u]);
                chk($sformatf("dut%0d m_last", u), int'(m_last_w[u]), int'(ml[u]));
                chk($sformatf("dut%0d m_sel", u), int'(m_sel_w[u]), ms[u]);
                chk($sformatf("dut%0d s_ready", u), int'(s_ready_w[u]),
                    (mb[u] != 0 && (!mv[u] || m_ready)) ? (1 << mg[u]) : 0);
                if (ph[u]) chk($sformatf("dut%0d hold m_data", u), int'(m_data_w[u]), int'(pd[u]));
                ph[u] = m_valid_w[u] && !m_ready;
                pd[u] = m_data_w[u];
            end
            if (m_valid_w[act] && m_ready)
                olog.push_back('{int'(m_sel_w[act]), int'(m_data_w[act]), int'(m_last_w[act]), cyc});
        end
    end

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            if (srcq[c].size() > 0) begin
                s_valid[c]         = 1'b1;
                s_last[c]          = srcq[c][0][8];
                s_data[c*W +: W]   = srcq[c][0][7:0];
            end else begin
                s_valid[c]         = 1'b0;
                s_last[c]          = 1'b0;
                s_data[c*W +: W]   = '0;
            end
        end
        m_ready = (mr_q.size() > 0) ? mr_q.pop_front() : 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        last_acc = s_valid & s_ready_w[act];
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (last_acc[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
        end
        drive();
    endtask

    task automatic pkt(input int c, input int base, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            srcq[c].push_back({(k == nbeats - 1) ? 1'b1 : 1'b0, 8'(base + k)});
        end
    endtask

    task automatic clear_src();
        for (int c = 0; c < N; c++) srcq[c].delete();
        mr_q.delete();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        clear_src();
        drive();
        repeat (n) tick();
        rst_n = 1'b1;
        olog.delete();
    endtask

    function automatic bit idle_all();
        for (int c = 0; c < N; c++) if (srcq[c].size() > 0) return 1'b0;
        return !mv[act] && (mb[act] == 0);
    endfunction

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (!idle_all() && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk({name, " drain timeout"}, n, -1);
    endtask

    initial begin
        int got;
        int n;
        int ord [6];
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b1;
        last_acc = '0;

        // 1: reset held with every channel requesting
        act = 0;
        clear_src();
        for (int c = 0; c < N; c++) pkt(c, 8'h10 + c, 1);
        drive();
        repeat (3) begin
            tick();
            chk("t1 rst m_valid", int'(m_valid_w[0]), 0);
            chk("t1 rst s_ready", int'(s_ready_w[0]), 0);
            chk("t1 rst m_sel", int'(m_sel_w[0]), 0);
        end
        rst_n = 1'b1;
        olog.delete();
        drain("t1", 100);
        chk("t1 beats", olog.size(), 4);
        if (olog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1 sel", olog[i].sel, i);
                chk("t1 data", olog[i].data, 'h10 + i);
                if (i > 0) chk("t1 spacing", olog[i].cyc - olog[i-1].cyc, 2);
            end
        end

        // 2: round-robin over ch0, ch1, ch3 with 3-beat packets
        do_reset(2);
        for (int p = 0; p < 2; p++) begin
            pkt(0, (0 << 4) | (p << 2), 3);
            pkt(1, (1 << 4) | (p << 2), 3);
            pkt(3, (3 << 4) | (p << 2), 3);
        end
        drive();
        drain("t2", 200);
        ord = '{0, 1, 3, 0, 1, 3};
        chk("t2 beats", olog.size(), 18);
        if (olog.size() == 18) begin
            for (int i = 0; i < 18; i++) begin
                chk("t2 sel", olog[i].sel, ord[i/3]);
                chk("t2 data", olog[i].data, (ord[i/3] << 4) | ((i/9) << 2) | (i % 3));
                chk("t2 last", olog[i].last, (i % 3 == 2) ? 1 : 0);
            end
        end

        // 3: fixed priority, ch1 starves ch2 while it keeps requesting
        act = 1;
        do_reset(2);
        for (int p = 0; p < 3; p++) begin
            pkt(1, 'h20 + 2*p, 2);
            pkt(2, 'h40 + 2*p, 2);
        end
        drive();
        drain("t3", 200);
        chk("t3 beats", olog.size(), 12);
        if (olog.size() == 12) begin
            for (int i = 0; i < 6; i++) begin
                chk("t3 ch1 sel", olog[i].sel, 1);
                chk("t3 ch1 data", olog[i].data, 'h20 + i);
                chk("t3 ch2 sel", olog[i+6].sel, 2);
            end
        end
        act = 0;

        // 4: backpressure on a 4-beat ch2 packet
        do_reset(2);
        pkt(2, 'hA0, 4);
        repeat (4) begin
            mr_q.push_back(1'b1); mr_q.push_back(1'b0);
            mr_q.push_back(1'b0); mr_q.push_back(1'b1);
        end
        drive();
        drain("t4", 100);
        chk("t4 beats", olog.size(), 4);
        if (olog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4 data", olog[i].data, 'hA0 + i);
                chk("t4 last", olog[i].last, (i == 3) ? 1 : 0);
                chk("t4 sel", olog[i].sel, 2);
            end
        end

        // 5: pointer wraps from 3 to 0, single-beat packets
        do_reset(2);
        pkt(2, 'h50, 1);
        drive();
        drain("t5a", 50);
        pkt(0, 'h60, 1);
        pkt(3, 'h63, 1);
        drive();
        drain("t5b", 50);
        chk("t5 beats", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("t5 first sel", olog[1].sel, 3);
            chk("t5 first data", olog[1].data, 'h63);
            chk("t5 second sel", olog[2].sel, 0);
            chk("t5 second data", olog[2].data, 'h60);
            chk("t5 spacing", olog[2].cyc - olog[1].cyc, 2);
        end

        // 6: reset lands after beat 2 of a 5-beat ch1 packet
        do_reset(2);
        pkt(1, 'h70, 5);
        drive();
        got = 0;
        n   = 0;
        while (got < 2 && n < 50) begin
            tick();
            got += int'(last_acc[1]);
            n++;
        end
        chk("t6 accepted", got, 2);
        rst_n = 1'b0;
        clear_src();
        drive();
        tick();
        chk("t6 rst m_valid", int'(m_valid_w[0]), 0);
        chk("t6 rst s_ready", int'(s_ready_w[0]), 0);
        rst_n = 1'b1;
        pkt(0, 'h80, 1);
        pkt(1, 'h81, 1);
        drive();
        drain("t6", 50);
        chk("t6 beats", olog.size(), 4);
        if (olog.size() == 4) begin
            chk("t6 trunc data0", olog[0].data, 'h70);
            chk("t6 trunc data1", olog[1].data, 'h71);
            chk("t6 trunc last", olog[0].last + olog[1].last, 0);
            chk("t6 first after sel", olog[2].sel, 0);
            chk("t6 first after data", olog[2].data, 'h80);
            chk("t6 second after sel", olog[3].sel, 1);
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
